// File: rtl/simon_uart_pkg.sv
// Shared UART constants and the per-character FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simon_uart_pkg;

    localparam int DEF_DBITS   = 8;   // data bits per character
    localparam int DEF_SB_TICK = 16;  // sample ticks per stop bit
    localparam int DEF_NBYTES  = 8;   // characters per block
    localparam int OVERSAMPLE  = 16;  // sample ticks per start/data bit

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } char_state_t;

endpackage

// File: rtl/uart_char_tx.sv
// Serialises one UART character (start, DBITS data LSB-first, stop) on sample ticks.
// Latency: start bit on tx the clock after start; done strobes on the final stop tick.
// Backpressure: start is honoured in IDLE, or in STOP on the done clock for gap-free chaining.
//
// Ports: clk, reset (sync, active-high), sample_tick (16x baud), start/din (character
// request and data), tx (registered serial out, idle-high), done (combinational strobe,
// high on the clock the stop bit completes).
module uart_char_tx
    import simon_uart_pkg::*;
#(
    parameter int DBITS   = DEF_DBITS,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             start,
    input  logic [DBITS-1:0] din,
    output logic             tx,
    output logic             done
);

    localparam int TMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

    char_state_t      state;
    logic [TW-1:0]    tick;
    logic [BW-1:0]    nbit;
    logic [DBITS-1:0] shreg;

    // Strobe is combinational so the sequencer can hand over the next byte on the
    // same clock, letting the next start bit follow the stop bit with no idle gap.
    assign done = (state == ST_STOP) && sample_tick && (tick == SB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            tick  <= '0;
            nbit  <= '0;
            shreg <= '0;
            tx    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        state <= ST_START;
                        tick  <= '0;
                        shreg <= din;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample_tick) begin
                        if (tick == OS_LAST) begin
                            state <= ST_DATA;
                            tick  <= '0;
                            nbit  <= '0;
                            tx    <= shreg[0];
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_tick) begin
                        if (tick == OS_LAST) begin
                            tick <= '0;
                            if (nbit == BIT_LAST) begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end else begin
                                // tx takes the next bit before the shift lands
                                nbit  <= nbit + 1'b1;
                                shreg <= shreg >> 1;
                                tx    <= shreg[1];
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (sample_tick) begin
                        if (tick == SB_LAST) begin
                            tick <= '0;
                            if (start) begin
                                state <= ST_START;
                                shreg <= din;
                                tx    <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/block_tx_sender.sv
// Sends an NBYTES block as back-to-back UART characters, lowest byte first.
// Latency: start bit on tx the clock after an accepted load; done one clock after the last stop tick.
// Backpressure: load is ignored while busy or on the done clock; no queueing.
//
// Ports: clk_100MHz, reset (sync, active-high), sample_tick (16x baud), load/block_in
// (block request), tx (serial out), busy (block in progress), done (end-of-block pulse),
// bytes_left (characters not yet fully sent).
module block_tx_sender
    import simon_uart_pkg::*;
#(
    parameter int DBITS   = DEF_DBITS,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int NBYTES  = DEF_NBYTES
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic                    load,
    input  logic [DBITS*NBYTES-1:0] block_in,
    output logic                    tx,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              bytes_left
);

    localparam logic [3:0] NB = 4'(NBYTES);

    logic [DBITS*NBYTES-1:0] blk;   // bytes still to be handed to the character FSM
    logic                    accept;
    logic                    char_start;
    logic [DBITS-1:0]        char_din;
    logic                    char_done;
    logic                    more;

    // The done clock is excluded so a load coincident with done waits a clock.
    assign accept     = load && !busy && !done;
    assign more       = busy && char_done && (bytes_left != 4'd1);
    assign char_start = accept || more;
    assign char_din   = accept ? block_in[DBITS-1:0] : blk[DBITS-1:0];

    uart_char_tx #(
        .DBITS   (DBITS),
        .SB_TICK (SB_TICK)
    ) u_char (
        .clk         (clk_100MHz),
        .reset       (reset),
        .sample_tick (sample_tick),
        .start       (char_start),
        .din         (char_din),
        .tx          (tx),
        .done        (char_done)
    );

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            blk        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bytes_left <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // byte 0 goes straight to the character FSM; keep the rest
                blk        <= block_in >> DBITS;
                busy       <= 1'b1;
                bytes_left <= NB;
            end else if (busy && char_done) begin
                bytes_left <= bytes_left - 4'd1;
                if (bytes_left == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    blk <= blk >> DBITS;
                end
            end
        end
    end

endmodule

// File: tb/tb_block_tx_sender.sv
module tb_block_tx_sender;

    logic        clk_100MHz;
    logic        reset;
    logic        sample_tick;
    logic        load;
    logic [63:0] block_in;
    logic        tx;
    logic        busy;
    logic        done;
    logic [3:0]  bytes_left;

    int n_checks = 0;
    int n_pass   = 0;
    int div      = 1;   // clocks per sample_tick

    block_tx_sender dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .sample_tick (sample_tick),
        .load        (load),
        .block_in    (block_in),
        .tx          (tx),
        .busy        (busy),
        .done        (done),
        .bytes_left  (bytes_left)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    // sample_tick: one clock in every div, updated just after each rising edge
    initial begin
        int tcnt;
        tcnt = 0;
        sample_tick = 1'b0;
        forever begin
            @(posedge clk_100MHz);
            #1;
            if (div <= 1) begin
                sample_tick = 1'b1;
            end else begin
                tcnt = (tcnt + 1 >= div) ? 0 : tcnt + 1;
                sample_tick = (tcnt == 0);
            end
        end
    end

    typedef struct {
        logic [63:0]     blk;
        int              dv;
        logic [7:0][7:0] exp;    // exp[i] = i-th character on the line
        int              inj_t;  // clock offset of an extra load while busy, -1 for none
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #2;
    endtask

    // Wait until the coming edge carries a sample tick so bit lengths are exact.
    task automatic align();
        for (int i = 0; i < 20; i++) begin
            step();
            if (sample_tick) break;
        end
    endtask

    task automatic run_block(input vec_t v, input int idx);
        int per, errs, first_bad, c, bt;
        logic etx;
        div = v.dv;
        step(); step();
        align();
        block_in = v.blk;
        load = 1'b1;
        step();
        load = 1'b0;
        per = 160 * div;
        errs = 0;
        first_bad = -1;
        for (int t = 0; t < 8 * per; t++) begin
            c  = t / per;
            bt = ((t % per) / div) / 16;
            if (bt == 0)      etx = 1'b0;
            else if (bt == 9) etx = 1'b1;
            else              etx = v.exp[c][bt-1];
            if (tx !== etx || busy !== 1'b1 || done !== 1'b0 || bytes_left !== 4'(8 - c)) begin
                if (errs == 0) first_bad = t;
                errs++;
            end
            if (t == v.inj_t) begin
                block_in = ~v.blk;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (t % per == per - 1) begin
                check($sformatf("vec%0d char%0d bad clocks (first at %0d)", idx, c, first_bad),
                      64'(errs), 64'd0);
                errs = 0;
                first_bad = -1;
            end
            step();
        end
        load = 1'b0;
        check($sformatf("vec%0d end {done,busy,bytes_left,tx}", idx),
              {57'd0, done, busy, bytes_left, tx}, {57'd0, 1'b1, 1'b0, 4'd0, 1'b1});
        errs = 0;
        for (int i = 0; i < 200 * div; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) errs++;
        end
        check($sformatf("vec%0d quiet clocks after done", idx), 64'(errs), 64'd0);
    endtask

    initial begin
        int errs;
        int found;
        vecs[0] = '{64'h0123456789ABCDEF, 1,
                    {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF}, -1};
        vecs[1] = '{64'h00000000000000FF, 4,
                    {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, -1};
        vecs[2] = '{64'h0123456789ABCDEF, 2,
                    {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF}, 3 * 320 + 100};
        vecs[3] = '{64'h80017E3C55AAC3F0, 1,
                    {8'h80, 8'h01, 8'h7E, 8'h3C, 8'h55, 8'hAA, 8'hC3, 8'hF0}, -1};

        reset = 1'b1;
        load = 1'b0;
        block_in = '0;
        repeat (3) step();
        check("reset {tx,busy,done,bytes_left}", {57'd0, tx, busy, done, bytes_left},
              {57'd0, 1'b1, 1'b0, 1'b0, 4'd0});
        // reset wins over a simultaneous load
        load = 1'b1;
        block_in = 64'h1111111111111111;
        step();
        load = 1'b0;
        check("reset over load busy", 64'(busy), 64'd0);
        step();
        reset = 1'b0;
        step();
        check("idle tx", 64'(tx), 64'd1);

        for (int i = 0; i < 4; i++) run_block(vecs[i], i);

        // reset during data bit 3 of byte 2 (0xAB, bit 3 = 1)
        div = 1;
        align();
        block_in = 64'h0123456789ABCDEF;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * 160 + 16 * 4 + 8) step();
        check("byte2 bit3 tx before reset", 64'(tx), 64'd1);
        check("bytes_left before reset", 64'(bytes_left), 64'd6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("after reset {tx,busy,done,bytes_left}", {57'd0, tx, busy, done, bytes_left},
              {57'd0, 1'b1, 1'b0, 1'b0, 4'd0});
        errs = 0;
        for (int i = 0; i < 1400; i++) begin
            step();
            if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("aborted block stays silent", 64'(errs), 64'd0);

        // load coincident with done is ignored; one clock later it is taken
        align();
        block_in = 64'h0123456789ABCDEF;
        load = 1'b1;
        step();
        load = 1'b0;
        found = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (done === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("done seen within bound", 64'(found), 64'd1);
        block_in = 64'hFEDCBA9876543210;
        load = 1'b1;
        step();
        check("load on done ignored {busy,tx}", {62'd0, busy, tx}, {62'd0, 1'b0, 1'b1});
        step();
        load = 1'b0;
        check("load after done {busy,tx,bytes_left}", {58'd0, busy, tx, bytes_left},
              {58'd0, 1'b1, 1'b0, 4'd8});
        repeat (16) step();
        check("second block byte0 bit0 (0x10)", 64'(tx), 64'd0);
        repeat (64) step();
        check("second block byte0 bit4 (0x10)", 64'(tx), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
